// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: byte stream -> little-endian 32-bit words, holds the core in reset until loaded.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   // State entered once the data (or an empty length) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t            state_q, state_d;
   logic [7:0]        len_lo_q;
   logic [15:0]       len_q;
   logic [ADDR_W:0]   word_idx_q;
   logic [1:0]        lane_q;
   logic [23:0]       asm_q;
   logic [7:0]        sum_q;

   logic [15:0]       len_full;
   logic              len_zero;
   logic              len_over;
   logic              last_word;
   logic              xfer;

   assign len_full  = {rx_data, len_lo_q};
   assign len_zero  = (len_full == 16'd0);
   assign len_over  = (32'(len_full) > (32'd1 << ADDR_W));
   assign last_word = ((32'(word_idx_q) + 32'd1) == 32'(len_q));
   assign xfer      = rx_valid && rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d  = state_q;
      rx_ready = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_LEN0;
         end
         S_LEN0: begin
            rx_ready = 1'b1;
            if (rx_valid) state_d = S_LEN1;
         end
         S_LEN1: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (len_over)      state_d = S_ERR;
               else if (len_zero) state_d = S_TAIL;
               else               state_d = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            if (rx_valid && lane_q == 2'd3 && last_word) state_d = S_TAIL;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            rx_ready = 1'b1;
            if (rx_valid) state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         len_lo_q   <= '0;
         len_q      <= '0;
         word_idx_q <= '0;
         lane_q     <= '0;
         asm_q      <= '0;
         sum_q      <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
                  core_reset <= 1'b1;
                  word_idx_q <= '0;
                  lane_q     <= '0;
                  sum_q      <= '0;
               end else if (state_q == S_DONE) begin
                  // A DATA->DONE entry raises the flags here, one cycle after the last strobe.
                  load_done  <= 1'b1;
                  core_reset <= 1'b0;
               end
            end
            S_LEN0: begin
               if (xfer) len_lo_q <= rx_data;
            end
            S_LEN1: begin
               if (xfer) begin
                  len_q <= len_full;
                  if (len_over) load_error <= 1'b1;
`ifndef IMEM_LOADER_CHECKSUM_EN
                  else if (len_zero) begin
                     load_done  <= 1'b1;
                     core_reset <= 1'b0;
                  end
`endif
               end
            end
            S_DATA: begin
               if (xfer) begin
                  sum_q <= sum_q + rx_data;
                  if (lane_q == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_idx_q[ADDR_W-1:0];
                     imem_wdata <= {rx_data, asm_q};
                     word_idx_q <= word_idx_q + 1'b1;
                     lane_q     <= 2'd0;
                  end else begin
                     asm_q[{lane_q, 3'b000} +: 8] <= rx_data;
                     lane_q <= lane_q + 2'd1;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  if (rx_data == sum_q) begin
                     load_done  <= 1'b1;
                     core_reset <= 1'b0;
                  end else begin
                     load_error <= 1'b1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the pipelined RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory through a single write port. It holds the core in reset until a complete, optionally checksum-verified image has been written. It is the write side of the instruction memory that the IF stage reads.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `clk` input 1: core clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader accepts a byte. A byte transfers when `rx_valid && rx_ready` at a rising edge.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output ADDR_W: word address for the write.
- `imem_wdata` output 32: instruction word for the write.
- `core_reset` output 1: reset for the pipeline. It is 1 until a load completes successfully.
- `load_done` output 1: image loaded. Sticky until `start` or `reset`.
- `load_error` output 1: length overflow or checksum mismatch. Sticky until `start` or `reset`.

## Operation
- **Stream format:** LEN_LO, LEN_HI (16-bit word count N), then 4N data bytes, least-significant byte first per word. In checksum builds, a final CHK byte follows.
- **States:** IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR.
- **Reset values:** state=IDLE, `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `load_done`=0, `load_error`=0.
- **IDLE / DONE / ERR:**
  - On `start` the loader goes to LEN0.
  - It clears `load_done`/`load_error`, sets `core_reset`=1, and clears the word index, byte lane and running sum.
- **`rx_ready`:** 1 exactly in LEN0, LEN1, DATA and CHK. `start` is ignored in these states.
- **LEN0:** on a transfer, latch LEN_LO and go to LEN1.
- **LEN1:** on a transfer, latch LEN_HI, then:
  - N > 2^ADDR_W: go to ERR.
  - N == 0: go to CHK, or DONE when checksum is compiled out.
  - Otherwise: go to DATA.
- **DATA:**
  - Each transferred byte shifts into the assembly register at lane 0..3 and adds to the 8-bit running sum (mod 256).
  - On the lane-3 transfer, the loader registers `imem_wdata` = assembled word and `imem_addr` = word index, and pulses `imem_we` for the next cycle.
  - It then increments the word index and resets the lane to 0.
  - After word N-1 it goes to CHK, or DONE when checksum is compiled out.
- **Assembly register:** separate from `imem_wdata`, so a byte may be accepted in the same cycle `imem_we` is high.
- **`rx_valid` gaps:** allowed anywhere. State holds with no side effects.
- **DONE:** `load_done`=1, `core_reset`=0.
- **ERR:** `load_error`=1, `core_reset`=1. No further writes.
- **Reset mid-load:** all outputs return to reset values immediately. Memory contents written so far are undefined to the core, which stays in reset.

## Timing
- Byte-accept to `imem_we` latency: 1 cycle after the edge accepting lane 3. The strobe is high for exactly one cycle.
- **Without checksum:** `load_done` rises and `core_reset` falls 1 cycle after the final `imem_we` cycle.
- **With checksum:** `load_done`/`load_error` change on the edge after the CHK byte is accepted.
- Sustained throughput is 1 byte/cycle, so a full image takes 2+4N(+1) transfer cycles.
- `imem_addr` and `imem_wdata` hold their last written values between strobes.
- Word index is ADDR_W+1 bits internally. The length check prevents wrap-around.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`
  - **Defined:** CHK state present. The CHK byte must equal the mod-256 sum of all data bytes (the length bytes are excluded). A match goes to DONE; a mismatch goes to ERR.
  - **Undefined:** CHK state absent. The loader goes from DATA, or from LEN1 with N=0, directly to DONE, and no trailing byte is consumed.

## Test plan
1. **Good load.** `start`, then bytes 02 00 93 00 50 00 13 01 A0 00 97 at 1/cycle.
   - `imem_we` at addr 0 with 0x00500093, then addr 1 with 0x00A00113.
   - After CHK: `load_done`=1, `core_reset`=0.
2. **Bad checksum.** Same stream with CHK=98.
   - Both writes occur.
   - `load_error`=1, `load_done`=0, `core_reset` stays 1.
3. **Empty image.** Bytes 00 00 00.
   - No `imem_we`.
   - `load_done`=1 one edge after the CHK byte. Without the macro, one edge after LEN_HI.
4. **Overflow.** ADDR_W=8, bytes 01 01 (N=257).
   - ERR on the edge after LEN_HI, `rx_ready`=0, no writes.
   - Later bytes are not accepted.
5. **Backpressure and gaps.** Scenario 1 with `rx_valid` high every other cycle and random idle gaps.
   - Identical writes and final state.
   - `rx_ready` never drops during LEN0–CHK.
6. **Reset and restart.** Assert `reset` after the 5th byte of scenario 1.
   - All outputs go to reset values.
   - `start` plus the full stream then completes exactly as in scenario 1.
   - `start` pulsed mid-load is ignored.
